dice_display_scan: RTL

//  Time-multiplexing scheduler for the shared 7-segment bus of the dice roller.

---
 rtl/dice_display_scan.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dice_display_scan.sv
// Two-digit 7-segment scan scheduler with dead time, polarity straps and roll chase.
// Optional DISP_BRIGHTNESS_EN adds a bright[2:0] duty control.
module dice_display_scan #(
    parameter int SCAN_DIV = 1024,
    parameter int DEAD_CYC = 16,
    parameter int LZB      = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] digit1,
    input  logic [3:0] digit10,
    input  logic       rolling,
    input  logic       seg_pol,
    input  logic       com_pol,
`ifdef DISP_BRIGHTNESS_EN
    input  logic [2:0] bright,
`endif
    output logic [7:0] seg_out,
    output logic [1:0] com_out,
    output logic [1:0] com_oe
);

    typedef enum logic [1:0] {DEAD1, ONES, DEAD10, TENS} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt;
    logic [2:0]  chase;
    logic [7:0]  pat_q, pat_nxt;
    logic        load, last, dead_end, active;
    logic [3:0]  dsel;
    logic [2:0]  chase3;
    logic [7:0]  seg_nxt;
    logic [1:0]  com_nxt;

    function automatic logic [7:0] decode(input logic [3:0] d);
        logic [7:0] p;
        unique case (d)
            4'd0:    p = 8'h3F;
            4'd1:    p = 8'h06;
            4'd2:    p = 8'h5B;
            4'd3:    p = 8'h4F;
            4'd4:    p = 8'h66;
            4'd5:    p = 8'h6D;
            4'd6:    p = 8'h7D;
            4'd7:    p = 8'h07;
            4'd8:    p = 8'h7F;
            4'd9:    p = 8'h6F;
            4'd15:   p = 8'h00;
            default: p = 8'h40;
        endcase
        return p;
    endfunction

    assign last     = (cnt == 16'(SCAN_DIV - 1));
    assign dead_end = (cnt == 16'(DEAD_CYC - 1));
    assign chase3   = (chase >= 3'd3) ? chase - 3'd3 : chase + 3'd3;

`ifdef DISP_BRIGHTNESS_EN
    logic [2:0]  bright_q;
    logic [31:0] off, lim;
    assign off    = 32'(cnt) - 32'(DEAD_CYC);
    assign lim    = (32'(SCAN_DIV - DEAD_CYC) * (32'(bright_q) + 32'd1)) >> 3;
    assign active = (off < lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    bright_q <= 3'd7;
        else if (load) bright_q <= bright;
    end
`else
    assign active = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        unique case (state)
            DEAD1:  if (dead_end) begin state_nxt = ONES; load = 1'b1; end
            ONES:   if (last) state_nxt = DEAD10;
            DEAD10: if (dead_end) begin state_nxt = TENS; load = 1'b1; end
            TENS:   if (last) state_nxt = DEAD1;
            default: state_nxt = DEAD1;
        endcase
    end

    // Pattern is captured once per phase so mid-phase input changes never show.
    always_comb begin
        dsel    = (state_nxt == ONES) ? digit1 : digit10;
        pat_nxt = decode(dsel);
        if (rolling)
            pat_nxt = 8'h01 << ((state_nxt == ONES) ? chase : chase3);
        else if (state_nxt == TENS && LZB != 0 && digit10 == 4'd0)
            pat_nxt = 8'h00;
    end

    always_comb begin
        com_nxt = {2{~com_pol}};
        seg_nxt = {8{~seg_pol}};
        if ((state == ONES || state == TENS) && active) begin
            seg_nxt = seg_pol ? pat_q : ~pat_q;
            if (state == ONES) com_nxt[0] = com_pol;
            else               com_nxt[1] = com_pol;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DEAD1;
            cnt   <= 16'd0;
            chase <= 3'd0;
            pat_q <= 8'h00;
        end else begin
            state <= state_nxt;
            cnt   <= last ? 16'd0 : cnt + 16'd1;
            if (load) pat_q <= pat_nxt;
            if (!rolling)
                chase <= 3'd0;
            else if (state == TENS && last)
                chase <= (chase == 3'd5) ? 3'd0 : chase + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out <= 8'h00;
            com_out <= 2'b00;
            com_oe  <= 2'b00;
        end else begin
            seg_out <= seg_nxt;
            com_out <= com_nxt;
            com_oe  <= 2'b11;
        end
    end

endmodule
